vga_fb_arbiter: RTL and testbench

- Shares the single-port framebuffer RAM between two users: the VGA scanout line prefetch and the CPU bus.
- On each end-of-line pulse from the VGA timing generator, the block reads the next visible line into a ping-pong line buffer.
- Fetch has strict priority. The CPU gets all remaining RAM cycles through a req/ack handshake.

---
 rtl/vga_fb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: VGA line prefetch into a ping-pong line buffer
// with strict priority, CPU req/ack access in the remaining cycles.
module vga_fb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 17,
    parameter int LINE_WORDS = 160,
    parameter int V_VISIBLE  = 480,
    parameter int V_TOTAL    = 525
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              xmax,
    input  logic [9:0]        y,
    output logic              lb_we,
    output logic [7:0]        lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              lb_bank,
    output logic              fetch_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CPU_ACC,
        CPU_ACK
    } state_t;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [9:0]          pend_line_q, pend_line_d;
    logic                cur_bank_q, cur_bank_d;
    logic [7:0]          k_q, k_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                acc_we_q, acc_we_d;
    logic                ovr_q, ovr_d;
    logic                lb_we_q, lb_we_d;
    logic [7:0]          lb_addr_q, lb_addr_d;
    logic                lb_bank_q, lb_bank_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [9:0]          nl;
    logic [9:0]          line_sel;
    logic                trig;

    assign nl   = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    assign trig = xmax && (nl < 10'(V_VISIBLE));

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pend_line_d = pend_line_q;
        cur_bank_d  = cur_bank_q;
        k_d         = k_q;
        addr_d      = addr_q;
        acc_we_d    = acc_we_q;
        ovr_d       = ovr_q;
        lb_we_d     = (state_q == FETCH);
        lb_addr_d   = k_q;
        lb_bank_d   = cur_bank_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        line_sel    = pend_line_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        // Newest trigger always wins the pending slot
        if (trig) begin
            pend_line_d = nl;
            pending_d   = 1'b1;
            if (state_q == FETCH || pending_q) begin
                ovr_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pending_q || trig) begin
                    line_sel   = trig ? nl : pend_line_q;
                    state_d    = FETCH;
                    pending_d  = 1'b0;
                    cur_bank_d = line_sel[0];
                    k_d        = '0;
                    addr_d     = ADDR_W'(line_sel) * ADDR_W'(LINE_WORDS);
                end else if (cpu_req && !ack_q) begin
                    state_d = CPU_ACC;
                end
            end
            FETCH: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
                k_d      = k_q + 8'd1;
                addr_d   = addr_q + ADDR_W'(1);
                if (k_q == 8'(LINE_WORDS - 1)) begin
                    state_d = IDLE;
                end
            end
            CPU_ACC: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                acc_we_d  = cpu_we;
                state_d   = CPU_ACK;
            end
            CPU_ACK: begin
                if (!acc_we_q) begin
                    rdata_d = mem_rdata;
                end
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            pend_line_q <= '0;
            cur_bank_q  <= 1'b0;
            k_q         <= '0;
            addr_q      <= '0;
            acc_we_q    <= 1'b0;
            ovr_q       <= 1'b0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_bank_q   <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pend_line_q <= pend_line_d;
            cur_bank_q  <= cur_bank_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            acc_we_q    <= acc_we_d;
            ovr_q       <= ovr_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
            lb_bank_q   <= lb_bank_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    // RAM data lands one cycle after the read, alongside the registered index
    assign lb_data       = lb_we_q ? mem_rdata : '0;
    assign lb_we         = lb_we_q;
    assign lb_addr       = lb_addr_q;
    assign lb_bank       = lb_bank_q;
    assign fetch_overrun = ovr_q;
    assign cpu_ack       = ack_q;
    assign cpu_rdata     = rdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: line-fetch vector table, scoreboard on
// line-buffer writes, and hand-written CPU/contention/overrun/reset cases.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        xmax = 1'b0;
    logic [9:0]  y = '0;
    logic        lb_we;
    logic [7:0]  lb_addr;
    logic [31:0] lb_data;
    logic        lb_bank;
    logic        fetch_overrun;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    vga_fb_arbiter dut (
        .clk(clk), .reset_n(reset_n), .xmax(xmax), .y(y),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .lb_bank(lb_bank), .fetch_overrun(fetch_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: returns the stored word, or the address itself if never written
    logic [31:0] ram [logic [16:0]];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'(mem_addr);
        end
    end

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        b;
    } lbrec_t;

    lbrec_t exp_q[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    lbrec_t got, want;
    always @(negedge clk) begin
        if (lb_we) begin
            got = '{a: lb_addr, d: lb_data, b: lb_bank};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL lb_unexpected: got a=%0d d=%0h b=%0d", got.a, got.d, got.b);
            end else begin
                want = exp_q.pop_front();
                if (got === want) n_pass++;
                else $display("FAIL lb_write: got a=%0d d=%0h b=%0d expected a=%0d d=%0h b=%0d",
                              got.a, got.d, got.b, want.a, want.d, want.b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int line, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            exp_q.push_back('{a: 8'(k), d: 32'(line * 160 + k), b: line[0]});
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 0);
    endtask

    task automatic cpu_xfer(input logic we, input logic [16:0] a,
                            input logic [31:0] wd, output logic [31:0] rd);
        int gc, ac;
        gc = -1;
        ac = -1;
        rd = '0;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (gc < 0 && mem_en && mem_addr == a) begin
                gc = cyc;
                chk("cpu_grant_we", 64'(mem_we), 64'(we));
                if (we) chk("cpu_grant_wdata", 64'(mem_wdata), 64'(wd));
            end
            if (cpu_ack) begin
                ac = cyc;
                rd = cpu_rdata;
                cpu_req = 1'b0;
                break;
            end
        end
        cpu_req = 1'b0;
        chk("cpu_ack_latency", 64'(ac - gc), 2);
        tick();
        chk("cpu_ack_pulse", 64'(cpu_ack), 0);
    endtask

    typedef struct {
        int y;
        int line;
    } vec_t;

    vec_t vecs[6];
    int n, first, last, gnt, ack, trg, en_cnt;
    logic [16:0] fa;
    logic first_is_fetch, ovr;
    logic [31:0] rd;

    initial begin
        vecs[0] = '{9, 10};
        vecs[1] = '{524, 0};
        vecs[2] = '{479, -1};
        vecs[3] = '{500, -1};
        vecs[4] = '{0, 1};
        vecs[5] = '{478, 479};

        // Reset and idle
        repeat (3) tick();
        chk("rst_outs_held", 64'(|{lb_we, lb_addr, lb_data, lb_bank, fetch_overrun,
            cpu_rdata, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata}), 0);
        reset_n = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_en) en_cnt++;
        end
        chk("idle_no_mem_en", 64'(en_cnt), 0);
        chk("idle_outs", 64'(|{lb_we, fetch_overrun, cpu_rdata, cpu_ack, mem_addr}), 0);

        // Line fetch vectors
        foreach (vecs[r]) begin
            y = 10'(vecs[r].y);
            xmax = 1'b1;
            if (vecs[r].line >= 0) push_line(vecs[r].line, 160);
            n = 0;
            first = -1;
            last = -1;
            fa = '0;
            for (int i = 0; i < 200; i++) begin
                tick();
                xmax = 1'b0;
                if (mem_en && !mem_we) begin
                    n++;
                    if (first < 0) begin
                        first = cyc;
                        fa = mem_addr;
                    end
                    last = cyc;
                end
            end
            chk($sformatf("vec%0d_reads", r), 64'(n), vecs[r].line >= 0 ? 160 : 0);
            if (vecs[r].line >= 0) begin
                chk($sformatf("vec%0d_base", r), 64'(fa), 64'(vecs[r].line * 160));
                chk($sformatf("vec%0d_span", r), 64'(last - first + 1), 160);
            end
            drain($sformatf("vec%0d_drain", r));
        end

        // CPU write then read back
        cpu_xfer(1'b1, 17'h00123, 32'hDEADBEEF, rd);
        cpu_xfer(1'b0, 17'h00123, 32'h0, rd);
        chk("cpu_rdata", 64'(rd), 64'hDEADBEEF);

        // Contention: cpu_req and xmax together, fetch goes first
        y = 10'd9;
        xmax = 1'b1;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 17'h00200;
        cpu_wdata = 32'h12345678;
        push_line(10, 160);
        n = 0; last = -1; gnt = -1; ack = -1; first_is_fetch = 1'b0; first = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            xmax = 1'b0;
            if (mem_en && first < 0) begin
                first = cyc;
                first_is_fetch = !mem_we && mem_addr == 17'd1600;
            end
            if (mem_en && mem_we && mem_addr == 17'h00200 && gnt < 0) gnt = cyc;
            else if (mem_en && !mem_we) begin
                n++;
                last = cyc;
            end
            if (cpu_ack) begin
                ack = cyc;
                cpu_req = 1'b0;
                break;
            end
        end
        cpu_req = 1'b0;
        chk("cont_fetch_first", 64'(first_is_fetch), 1);
        chk("cont_fetch_reads", 64'(n), 160);
        chk("cont_grant_after_fetch", 64'(gnt > last && gnt > 0), 1);
        chk("cont_ack_latency", 64'(ack - gnt), 2);
        drain("cont_drain");

        // Contention: xmax during CPU grant, fetch starts within 3 cycles
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 17'h00123;
        gnt = -1; trg = -1; first = -1; rd = '0; ack = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            xmax = 1'b0;
            if (mem_en && mem_addr == 17'h00123 && gnt < 0) begin
                gnt = cyc;
                trg = cyc;
                y = 10'd99;
                xmax = 1'b1;
                push_line(100, 160);
            end
            if (mem_en && !mem_we && mem_addr == 17'd16000 && first < 0) first = cyc;
            if (cpu_ack) begin
                ack = cyc;
                rd = cpu_rdata;
                cpu_req = 1'b0;
            end
            if (first >= 0 && ack >= 0) break;
        end
        cpu_req = 1'b0;
        xmax = 1'b0;
        chk("busy_fetch_delay_ok", 64'(first > trg && first - trg <= 3 && trg >= 0), 1);
        chk("busy_cpu_rdata", 64'(rd), 64'hDEADBEEF);
        drain("busy_drain");

        // Overrun: second trigger at fetch word 50
        chk("ovr_pre", 64'(fetch_overrun), 0);
        y = 10'd9;
        xmax = 1'b1;
        push_line(10, 160);
        n = 0;
        ovr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            xmax = 1'b0;
            if (mem_en && !mem_we) n++;
            if (n == 51 && !ovr) begin
                y = 10'd19;
                xmax = 1'b1;
                push_line(20, 160);
                ovr = 1'b1;
            end
        end
        chk("ovr_reads", 64'(n), 320);
        chk("ovr_flag", 64'(fetch_overrun), 1);
        drain("ovr_drain");

        // Reset at fetch word 20
        y = 10'd0;
        xmax = 1'b1;
        push_line(1, 20);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            xmax = 1'b0;
            if (mem_en && !mem_we) n++;
            if (n == 21) begin
                reset_n = 1'b0;
                break;
            end
        end
        chk("rst_reached_word20", 64'(n), 21);
        tick();
        chk("rst_mem_en", 64'(mem_en), 0);
        chk("rst_lb_we", 64'(lb_we), 0);
        chk("rst_overrun", 64'(fetch_overrun), 0);
        tick();
        reset_n = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (mem_en) en_cnt++;
        end
        chk("rst_no_resume", 64'(en_cnt), 0);
        chk("rst_drain", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
